// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler: frame sequencer that wraps each frame in one zero line above and one below, throttled by prog_full.
// Optional macro CONV_SCHED_LINE_IRQ_EN adds the o_line_done per-line pulse output.
module conv_frame_scheduler #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int PIX_W      = 8,
  parameter int FCNT_W     = 16
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  input  logic              i_prog_full,
  output logic              m_valid,
  output logic [PIX_W-1:0]  m_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [FCNT_W-1:0] o_frame_cnt
`ifdef CONV_SCHED_LINE_IRQ_EN
  ,
  output logic              o_line_done
`endif
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  typedef enum logic [2:0] {IDLE, PAD_TOP, STREAM, PAD_BOT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic pad, issue, last_col, last_row;
  assign s_ready      = state == STREAM && !i_prog_full;
  assign o_busy       = state != IDLE;
  assign o_frame_done = state == DONE;
  always_comb begin
    pad      = state == PAD_TOP || state == PAD_BOT;
    issue    = !i_prog_full && (pad || (state == STREAM && s_valid));
    last_col = col == CW'(IMG_WIDTH - 1);
    last_row = row == RW'(IMG_HEIGHT - 1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_start ? PAD_TOP : IDLE;
      PAD_TOP: state_nx = issue && last_col ? STREAM : PAD_TOP;
      STREAM:  state_nx = issue && last_col && last_row ? PAD_BOT : STREAM;
      PAD_BOT: state_nx = issue && last_col ? DONE : PAD_BOT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) state <= IDLE;
    else state <= state_nx;
  // Counters wrap to zero on each state exit, so every pad/stream state is entered with them cleared.
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) begin
      col         <= '0;
      row         <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      o_frame_cnt <= '0;
    end else begin
      col         <= state == IDLE ? '0 : issue ? (last_col ? '0 : col + CW'(1)) : col;
      row         <= state == IDLE ? '0 : (issue && last_col && state == STREAM) ? (last_row ? '0 : row + RW'(1)) : row;
      m_valid     <= issue;
      m_data      <= issue ? (state == STREAM ? s_data : '0) : m_data;
      o_frame_cnt <= state == DONE ? o_frame_cnt + FCNT_W'(1) : o_frame_cnt;
    end
`ifdef CONV_SCHED_LINE_IRQ_EN
  always_ff @(posedge axi_clk or negedge axi_reset_n)
    if (!axi_reset_n) o_line_done <= 1'b0;
    else o_line_done <= issue && last_col;
`endif
endmodule

// File: tb/tb_conv_frame_scheduler.sv
// tb_conv_frame_scheduler: directed frame scenarios at 4x3, checking the 20-pixel padded output stream.
module tb_conv_frame_scheduler;
  localparam int W = 4, H = 3, PW = 8, FW = 16;
  logic axi_clk = 1'b0, axi_reset_n = 1'b0, i_start = 1'b0, s_valid = 1'b0, i_prog_full = 1'b0;
  logic [PW-1:0] s_data = '0;
  logic s_ready, m_valid, o_busy, o_frame_done;
  logic [PW-1:0] m_data;
  logic [FW-1:0] o_frame_cnt;
  int cmp = 0, errs = 0, done_seen = 0, ld_total = 0, exp_cnt = 0;
  logic [PW-1:0] got[$];
  bit ld_q[$];
`ifdef CONV_SCHED_LINE_IRQ_EN
  logic o_line_done;
`endif
  conv_frame_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .FCNT_W(FW)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_start(i_start), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .i_prog_full(i_prog_full), .m_valid(m_valid),
    .m_data(m_data), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt)
`ifdef CONV_SCHED_LINE_IRQ_EN
    , .o_line_done(o_line_done)
`endif
  );
  always #5 axi_clk = ~axi_clk;
  always @(negedge axi_clk) begin
    if (m_valid) got.push_back(m_data);
`ifdef CONV_SCHED_LINE_IRQ_EN
    if (m_valid) ld_q.push_back(o_line_done);
    if (o_line_done) ld_total++;
`endif
    if (o_frame_done) done_seen++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_frame_done"}, 32'(o_frame_done), 0);
    chk({tag, "_frame_cnt"}, 32'(o_frame_cnt), 0);
  endtask
  // Runs one frame; abort_at>0 pulls reset once that many pixels have been seen.
  task automatic run_frame(input bit pf_mode, input bit rand_v, input bit mid_start, input int abort_at);
    int next_data = 1, stall = 0, d0 = done_seen;
    bit stalled_once = 0, xfer;
    got.delete();
    ld_q.delete();
    ld_total = 0;
    for (int c = 0; c < 200 && done_seen == d0; c++) begin
      @(negedge axi_clk);
      #1;
      if (abort_at > 0 && got.size() >= abort_at) begin
        axi_reset_n = 1'b0;
        i_start = 1'b0;
        s_valid = 1'b0;
        i_prog_full = 1'b0;
        #1;
        chk_idle("abort");
        exp_cnt = 0;
        repeat (2) @(negedge axi_clk);
        axi_reset_n = 1'b1;
        return;
      end
      if (pf_mode && next_data == 6 && !stalled_once) begin
        stall = 3;
        stalled_once = 1;
      end
      i_start = c == 0 || (mid_start && c == 10);
      i_prog_full = (pf_mode && c >= 2 && c <= 6) || stall > 0;
      s_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = PW'(next_data);
      #1;
      if (i_prog_full) chk("stall_s_ready", 32'(s_ready), 0);
      xfer = s_valid && s_ready;
      @(posedge axi_clk);
      if (xfer) next_data++;
      if (stall > 0) stall--;
    end
    i_start = 1'b0;
    s_valid = 1'b0;
    i_prog_full = 1'b0;
    repeat (3) @(negedge axi_clk);
    #1;
    exp_cnt++;
    chk("frame_done_pulses", 32'(done_seen - d0), 1);
    chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
    chk("busy_after", 32'(o_busy), 0);
    chk("pulse_count", 32'(got.size()), 20);
    for (int i = 0; i < got.size() && i < 20; i++)
      chk($sformatf("pix%0d", i), 32'(got[i]), (i < 4 || i >= 16) ? 0 : 32'(i - 3));
  endtask
  initial begin
    repeat (3) @(negedge axi_clk);
    #1;
    chk_idle("reset");
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    #1;
    chk_idle("post_reset");
    run_frame(0, 0, 0, 0);
`ifdef CONV_SCHED_LINE_IRQ_EN
    chk("line_done_total", 32'(ld_total), 5);
    for (int i = 0; i < ld_q.size(); i++)
      chk($sformatf("line_done%0d", i), 32'(ld_q[i]), 32'(i % 4 == 3));
`endif
    run_frame(1, 0, 0, 0);
    run_frame(0, 1, 1, 0);
    run_frame(0, 0, 0, 9);
    chk("abort_reset_cnt", 32'(o_frame_cnt), 0);
    run_frame(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
